dvp_tx: RTL and testbench

- DVP (camera parallel-port) transmitter: the sensor side of the CMOS capture interface.
- Takes RGB565 pixels over a valid/ready stream and emits vsync/href/8-bit data with programmable blanking, matching what our camera-capture input path expects.
- Used as a camera emulator for loopback testing of the video input/processing/DMA chain without a sensor, and as a DVP output to external devices.

---
 rtl/dvp_tx.sv | 162 ++++++++++++++++
 tb/tb_dvp_tx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dvp_tx.sv
// DVP (camera parallel-port) transmitter: streams RGB565 pixels out as vsync/href/8-bit bytes
// with programmable horizontal and vertical blanking.
module dvp_tx #(
  parameter int unsigned H_ACT   = 1280,
  parameter int unsigned V_ACT   = 720,
  parameter int unsigned H_BLANK = 256,
  parameter int unsigned V_SYNC  = 4,
  parameter int unsigned V_BACK  = 16,
  parameter int unsigned V_FRONT = 4,
  parameter bit          VS_POL  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        pix_valid,
  input  logic [15:0] pix_data,
  input  logic        pix_sof,
  output logic        pix_ready,
  output logic        dvp_vsync,
  output logic        dvp_href,
  output logic [7:0]  dvp_db,
  output logic        frame_done,
  output logic        underflow,
  output logic        sync_err
);

  localparam int unsigned LineLen = 2 * H_ACT + H_BLANK;
  localparam int unsigned HW      = $clog2(LineLen + 1);
  localparam int unsigned VMaxA   = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
  localparam int unsigned VMaxB   = (V_ACT > V_FRONT) ? V_ACT : V_FRONT;
  localparam int unsigned VMax    = (VMaxA > VMaxB) ? VMaxA : VMaxB;
  localparam int unsigned VW      = $clog2(VMax + 1);

  localparam logic [HW-1:0] HLast   = HW'(LineLen - 1);
  localparam logic [HW-1:0] HActEnd = HW'(2 * H_ACT);
  localparam logic [VW-1:0] VSyncLast  = VW'(V_SYNC - 1);
  localparam logic [VW-1:0] VBackLast  = VW'(V_BACK - 1);
  localparam logic [VW-1:0] VActLast   = VW'(V_ACT - 1);
  localparam logic [VW-1:0] VFrontLast = VW'(V_FRONT - 1);

  typedef enum logic [2:0] {StIdle, StVsync, StVback, StActive, StVfront} state_e;

  // Zero-length vertical regions are skipped when entering a new frame.
  localparam state_e AfterSync = (V_BACK != 0) ? StVback : StActive;
  localparam state_e FirstSt   = (V_SYNC != 0) ? StVsync : AfterSync;

  state_e          state_q, state_d;
  logic [HW-1:0]   h_q, h_d;
  logic [VW-1:0]   v_q, v_d;
  logic [7:0]      lo_q, lo_d;
  logic [7:0]      db_q, db_d;
  logic            vsync_q, vsync_d;
  logic            href_q, href_d;
  logic            frame_done_q, frame_done_d;
  logic            underflow_q, underflow_d;
  logic            sync_err_q, sync_err_d;

  logic            line_end;
  logic            v_last;
  logic [VW-1:0]   v_last_val;
  logic            in_act;
  logic            first_slot;
  logic            xfer;

  always_comb begin
    v_last_val = '0;
    unique case (state_q)
      StVsync:  v_last_val = VSyncLast;
      StVback:  v_last_val = VBackLast;
      StActive: v_last_val = VActLast;
      StVfront: v_last_val = VFrontLast;
      default:  v_last_val = '0;
    endcase
  end

  always_comb begin
    line_end = (h_q == HLast);
    v_last   = (v_q == v_last_val);
    state_d  = state_q;
    h_d      = h_q;
    v_d      = v_q;
    if (state_q == StIdle) begin
      h_d = '0;
      v_d = '0;
      if (enable) begin
        state_d = FirstSt;
      end
    end else begin
      h_d = line_end ? '0 : h_q + 1'b1;
      if (line_end) begin
        if (v_last) begin
          v_d = '0;
          unique case (state_q)
            StVsync:  state_d = AfterSync;
            StVback:  state_d = StActive;
            StActive: state_d = (V_FRONT != 0) ? StVfront : (enable ? FirstSt : StIdle);
            StVfront: state_d = enable ? FirstSt : StIdle;
            default:  state_d = StIdle;
          endcase
        end else begin
          v_d = v_q + 1'b1;
        end
      end
    end
  end

  assign in_act     = (state_q == StActive) && (h_q < HActEnd);
  assign pix_ready  = in_act && !h_q[0];
  assign xfer       = pix_ready && pix_valid;
  assign first_slot = (state_q == StActive) && (v_q == '0) && (h_q == '0);

  always_comb begin
    vsync_d      = (state_q == StVsync) ? VS_POL : ~VS_POL;
    href_d       = in_act;
    db_d         = 8'h00;
    lo_d         = lo_q;
    if (pix_ready) begin
      // A missed slot still occupies its two byte cycles, as zeros.
      db_d = pix_valid ? pix_data[15:8] : 8'h00;
      lo_d = pix_valid ? pix_data[7:0] : 8'h00;
    end else if (in_act) begin
      db_d = lo_q;
    end
    frame_done_d = (state_q == StActive) && (v_q == VActLast) && (h_q == HActEnd);
    underflow_d  = underflow_q | (pix_ready & ~pix_valid);
    sync_err_d   = xfer && (first_slot ? !pix_sof : pix_sof);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      h_q          <= '0;
      v_q          <= '0;
      lo_q         <= 8'h00;
      db_q         <= 8'h00;
      vsync_q      <= ~VS_POL;
      href_q       <= 1'b0;
      frame_done_q <= 1'b0;
      underflow_q  <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      h_q          <= h_d;
      v_q          <= v_d;
      lo_q         <= lo_d;
      db_q         <= db_d;
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      frame_done_q <= frame_done_d;
      underflow_q  <= underflow_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign dvp_vsync  = vsync_q;
  assign dvp_href   = href_q;
  assign dvp_db     = db_q;
  assign frame_done = frame_done_q;
  assign underflow  = underflow_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_dvp_tx.sv
// Scoreboard bench for dvp_tx on a small 14x7 timing: the driver queues expected bytes per pixel
// slot, a monitor pops them whenever href is high, and the main thread checks frame timing.
module tb_dvp_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        pix_sof;
  logic        pix_ready;
  logic        dvp_vsync;
  logic        dvp_href;
  logic [7:0]  dvp_db;
  logic        frame_done;
  logic        underflow;
  logic        sync_err;

  int nvec  = 0;
  int nfail = 0;

  typedef struct packed {
    logic [7:0] db;
    logic       err;
    logic       uf;
  } exp_t;
  exp_t q[$];

  dvp_tx #(
    .H_ACT  (4),
    .V_ACT  (3),
    .H_BLANK(6),
    .V_SYNC (1),
    .V_BACK (2),
    .V_FRONT(1),
    .VS_POL (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_sof   (pix_sof),
    .pix_ready (pix_ready),
    .dvp_vsync (dvp_vsync),
    .dvp_href  (dvp_href),
    .dvp_db    (dvp_db),
    .frame_done(frame_done),
    .underflow (underflow),
    .sync_err  (sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic rst_check(input string name);
    chk(name, {dvp_vsync, dvp_href, dvp_db, frame_done, underflow, sync_err, pix_ready}, 32'h0);
  endtask

  // Frame position p=0 is the first sample with vsync high; 14 samples per line.
  task automatic check_frame(input string name, input int nsamp, input bit drop_en);
    int bad = 0;
    int line, h, qn, ql, qh;
    logic [3:0] e;
    for (int p = 0; p < nsamp; p++) begin
      @(negedge clk);
      if (drop_en && p == 50) enable = 1'b0;
      line = p / 14;
      h    = p % 14;
      qn   = (p + 1) % 98;
      ql   = qn / 14;
      qh   = qn % 14;
      e[3] = (line == 0);
      e[2] = (line >= 3) && (line <= 5) && (h < 8);
      e[1] = (line == 5) && (h == 8);
      e[0] = (ql >= 3) && (ql <= 5) && (qh < 8) && (qh % 2 == 0);
      if ({dvp_vsync, dvp_href, frame_done, pix_ready} !== e) begin
        if (bad == 0)
          $display("FAIL %s at cycle %0d: vsync/href/done/ready got %b expected %b", name, p,
                   {dvp_vsync, dvp_href, frame_done, pix_ready}, e);
        bad++;
      end
    end
    nvec++;
    if (bad != 0) nfail++;
  endtask

  task automatic check_idle(input string name, input int n, input logic uf);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if ({dvp_vsync, dvp_href, frame_done, pix_ready, underflow} !== {4'b0000, uf}) begin
        if (bad == 0)
          $display("FAIL %s at cycle %0d: vsync/href/done/ready/uf got %b expected %b", name, i,
                   {dvp_vsync, dvp_href, frame_done, pix_ready, underflow}, {4'b0000, uf});
        bad++;
      end
    end
    nvec++;
    if (bad != 0) nfail++;
  endtask

  // Driver: frame 1 drops slot 5, frame 2 moves SOF from slot 0 to slot 5.
  int   slot = 0;
  int   frm  = 0;
  int   npix = 0;
  logic uf_m = 1'b0;
  initial begin : driver
    logic [15:0] d;
    logic        e;
    pix_valid = 1'b1;
    pix_data  = 16'h1234;
    pix_sof   = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        slot = 0;
        uf_m = 1'b0;
        if (frm != 0) frm = 10;
      end else if (pix_ready) begin
        if (pix_valid) begin
          d = pix_data;
          e = ((slot == 0) != pix_sof);
          q.push_back('{db: d[15:8], err: e, uf: uf_m});
          q.push_back('{db: d[7:0], err: 1'b0, uf: uf_m});
          npix++;
        end else begin
          uf_m = 1'b1;
          q.push_back('{db: 8'h00, err: 1'b0, uf: 1'b1});
          q.push_back('{db: 8'h00, err: 1'b0, uf: 1'b1});
        end
        slot++;
        if (slot == 12) begin
          slot = 0;
          frm++;
        end
      end
      @(posedge clk);
      #1;
      pix_valid = !(frm == 1 && slot == 5);
      pix_data  = 16'h1234 + 16'(npix) * 16'h4444;
      pix_sof   = (frm == 2) ? (slot == 5) : (slot == 0);
    end
  end

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
      end else if (dvp_href) begin
        if (q.size() == 0) begin
          nvec++;
          nfail++;
          $display("FAIL pixel_byte: got db=%02h with no byte expected", dvp_db);
        end else begin
          x = q.pop_front();
          chk("pixel_byte db/err/uf", {dvp_db, sync_err, underflow}, {x.db, x.err, x.uf});
        end
      end else begin
        chk("blank_db_err", {dvp_db, sync_err}, 9'h000);
      end
    end
  end

  initial begin : main
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_check("reset_values");
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_idle("idle_no_enable", 5, 1'b0);

    @(posedge clk);
    #1 enable = 1'b1;
    check_idle("pre_vsync", 2, 1'b0);
    check_frame("frame0_basic", 98, 1'b0);
    check_frame("frame1_underrun", 98, 1'b0);
    check_frame("frame2_sof", 98, 1'b0);
    check_frame("frame3_disable", 98, 1'b1);
    check_idle("idle_after_disable", 20, 1'b1);
    chk("underflow_sticky", {31'h0, underflow}, 32'h1);

    @(posedge clk);
    #1 enable = 1'b1;
    check_idle("pre_vsync2", 2, 1'b1);
    check_frame("frame_pre_reset", 44, 1'b0);
    #1 rst_n = 1'b0;
    #1 rst_check("async_reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_idle("pre_vsync3", 2, 1'b0);
    check_frame("frame_after_reset", 98, 1'b1);
    check_idle("idle_final", 10, 1'b0);
    chk("queue_drained", q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
